// File: rtl/usb_line_xcvr.sv
// ---------------------------------------------------------------------------
// usb_line_xcvr
//   Half-duplex DP/DM line transceiver between the encoding/unencoding
//   pipelines and the bus pins.
//
//   TX: pulls tx_len bits (sync included) from the encoder one per cycle.
//   It then drives EOP_CYCLES of SE0 and one idle J, and returns to idle.
//   RX: hunts for the KJKJ..KK sync pattern. It then streams packet bits out.
//   It checks the SE0 EOP length and reports the data bit count. It flags
//   line errors and enforces a sync-arrival timeout armed by rx_arm.
//
// Ports
//   clk, rst_b          clock, asynchronous active-low reset
//   tx_start_i          start request (only honoured while TX is idle)
//   tx_len_i            bits to send incl. sync, clamped to MAX_BITS
//   tx_bit_i            current encoder bit, consumed when tx_bit_req_o=1
//   tx_bit_req_o        pull strobe towards the encoder
//   tx_busy_o           TX is not idle (also blanks the receiver)
//   tx_done_o           one-cycle pulse in the trailing J cycle
//   oe_o, dp_w_o, dm_w_o  pin drive
//   dp_r_i, dm_r_i      pin sense
//   rx_en_i             receive enable
//   rx_arm_i            starts/restarts the sync timeout window
//   rx_valid_o, rx_bit_o  received data bit strobe and value
//   rx_done_o           one-cycle pulse after a valid EOP
//   rx_len_o            data bits of the last good packet
//   rx_err_o            one-cycle pulse on a line error
//   rx_timeout_o        one-cycle pulse when the timeout window expires
// ---------------------------------------------------------------------------
module usb_line_xcvr #(
    parameter int SYNC_BITS  = 8,
    parameter int EOP_CYCLES = 2,
    parameter int MAX_BITS   = 127,
    parameter int RX_TIMEOUT = 255,
    parameter int LEN_W      = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             tx_start_i,
    input  logic [LEN_W-1:0] tx_len_i,
    input  logic             tx_bit_i,
    output logic             tx_bit_req_o,
    output logic             tx_busy_o,
    output logic             tx_done_o,
    output logic             oe_o,
    output logic             dp_w_o,
    output logic             dm_w_o,
    input  logic             dp_r_i,
    input  logic             dm_r_i,
    input  logic             rx_en_i,
    input  logic             rx_arm_i,
    output logic             rx_valid_o,
    output logic             rx_bit_o,
    output logic             rx_done_o,
    output logic [LEN_W-1:0] rx_len_o,
    output logic             rx_err_o,
    output logic             rx_timeout_o
);

    localparam int SYNC_W     = $clog2(SYNC_BITS);
    localparam int EOP_W      = $clog2(EOP_CYCLES + 1);
    localparam int TMR_W      = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam int TMR_LAST_I = (RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0;
    localparam bit TIMEOUT_EN = (RX_TIMEOUT > 0);

    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_BITS);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BITS - 1);
    localparam logic [SYNC_W-1:0] SYNC_ONE  = SYNC_W'(1);
    localparam logic [EOP_W-1:0]  EOP_LAST  = EOP_W'(EOP_CYCLES - 1);
    localparam logic [EOP_W-1:0]  EOP_MAX   = EOP_W'(EOP_CYCLES);
    localparam logic [EOP_W-1:0]  EOP_ONE   = EOP_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TMR_LAST_I);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);

    // =======================================================================
    // Transmitter
    // =======================================================================
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_EOP, TX_J} tx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [LEN_W-1:0] tx_len_q, tx_len_d;
    logic [LEN_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [EOP_W-1:0] tx_eop_q, tx_eop_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tx_state_q <= TX_IDLE;
            tx_len_q   <= '0;
            tx_cnt_q   <= '0;
            tx_eop_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_len_q   <= tx_len_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_eop_q   <= tx_eop_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_len_d   = tx_len_q;
        tx_cnt_d   = tx_cnt_q;
        tx_eop_d   = tx_eop_q;
        case (tx_state_q)
            TX_IDLE: begin
                // A zero-length request has nothing to send, so it is dropped.
                if (tx_start_i && (tx_len_i != '0)) begin
                    tx_state_d = TX_SEND;
                    tx_len_d   = (tx_len_i > MAX_LEN) ? MAX_LEN : tx_len_i;
                    tx_cnt_d   = '0;
                end
            end
            TX_SEND: begin
                if (tx_cnt_q == tx_len_q - LEN_ONE) begin
                    tx_state_d = TX_EOP;
                    tx_cnt_d   = '0;
                    tx_eop_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + LEN_ONE;
                end
            end
            TX_EOP: begin
                if (tx_eop_q == EOP_LAST) begin
                    tx_state_d = TX_J;
                    tx_eop_d   = '0;
                end else begin
                    tx_eop_d = tx_eop_q + EOP_ONE;
                end
            end
            TX_J:    tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // The encoder bit passes straight to the pins in the same cycle it is
    // pulled, so the encoder must present tx_bit_i combinationally.
    always_comb begin
        tx_bit_req_o = 1'b0;
        tx_done_o    = 1'b0;
        oe_o         = 1'b0;
        dp_w_o       = 1'b1;
        dm_w_o       = 1'b0;
        case (tx_state_q)
            TX_SEND: begin
                oe_o         = 1'b1;
                tx_bit_req_o = 1'b1;
                dp_w_o       = tx_bit_i;
                dm_w_o       = ~tx_bit_i;
            end
            TX_EOP: begin
                oe_o   = 1'b1;
                dp_w_o = 1'b0;
                dm_w_o = 1'b0;
            end
            TX_J: begin
                oe_o      = 1'b1;
                tx_done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign tx_busy_o = (tx_state_q != TX_IDLE);

    // =======================================================================
    // Receiver
    // =======================================================================
    typedef enum logic [1:0] {RX_SEEK, RX_DATA, RX_EOP} rx_state_e;

    rx_state_e         rx_state_q, rx_state_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [EOP_W-1:0]  se0_cnt_q, se0_cnt_d;
    logic [LEN_W-1:0]  rx_len_q, rx_len_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_err_q, rx_err_d;

    logic rx_active;
    logic line_j, line_k, line_se0;
    logic sync_exp_k, sync_match, sync_det;

    assign rx_active = rx_en_i && !tx_busy_o;

    assign line_j   =  dp_r_i && !dm_r_i;
    assign line_k   = !dp_r_i &&  dm_r_i;
    assign line_se0 = !dp_r_i && !dm_r_i;

    // Sync is K on even indices, J on odd ones, except the last symbol,
    // which is a second K.
    assign sync_exp_k = (sync_cnt_q == SYNC_LAST) || !sync_cnt_q[0];
    assign sync_match = sync_exp_k ? line_k : line_j;
    assign sync_det   = rx_active && (rx_state_q == RX_SEEK) && sync_match &&
                        (sync_cnt_q == SYNC_LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rx_state_q <= RX_SEEK;
            sync_cnt_q <= '0;
            bit_cnt_q  <= '0;
            se0_cnt_q  <= '0;
            rx_len_q   <= '0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            sync_cnt_q <= sync_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            se0_cnt_q  <= se0_cnt_d;
            rx_len_q   <= rx_len_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        sync_cnt_d = sync_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        se0_cnt_d  = se0_cnt_q;
        rx_len_d   = rx_len_q;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;
        if (!rx_active) begin
            // Own transmission or disabled receiver: silently abandon any
            // packet in progress.
            rx_state_d = RX_SEEK;
            sync_cnt_d = '0;
            bit_cnt_d  = '0;
            se0_cnt_d  = '0;
        end else begin
            case (rx_state_q)
                RX_SEEK: begin
                    if (sync_match) begin
                        if (sync_cnt_q == SYNC_LAST) begin
                            rx_state_d = RX_DATA;
                            sync_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            sync_cnt_d = sync_cnt_q + SYNC_ONE;
                        end
                    end else begin
                        // A stray K may itself be the first sync symbol.
                        sync_cnt_d = line_k ? SYNC_ONE : '0;
                    end
                end
                RX_DATA: begin
                    if (line_j || line_k) begin
                        if (bit_cnt_q == MAX_LEN) begin
                            rx_err_d   = 1'b1;
                            rx_state_d = RX_SEEK;
                            bit_cnt_d  = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + LEN_ONE;
                        end
                    end else if (line_se0) begin
                        rx_state_d = RX_EOP;
                        se0_cnt_d  = EOP_ONE;
                    end else begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_SEEK;
                        bit_cnt_d  = '0;
                    end
                end
                RX_EOP: begin
                    if (line_se0) begin
                        // Saturate: anything at or beyond EOP_CYCLES is
                        // equally acceptable.
                        if (se0_cnt_q != EOP_MAX) se0_cnt_d = se0_cnt_q + EOP_ONE;
                    end else begin
                        if (line_j && (se0_cnt_q == EOP_MAX)) begin
                            rx_done_d = 1'b1;
                            rx_len_d  = bit_cnt_q;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                        rx_state_d = RX_SEEK;
                        bit_cnt_d  = '0;
                        se0_cnt_d  = '0;
                    end
                end
                default: rx_state_d = RX_SEEK;
            endcase
        end
    end

    // A data symbol that would overflow is reported as an error, not a bit.
    always_comb begin
        rx_valid_o = rx_active && (rx_state_q == RX_DATA) &&
                     (line_j || line_k) && (bit_cnt_q != MAX_LEN);
        rx_bit_o   = rx_valid_o && dp_r_i;
    end

    assign rx_done_o = rx_done_q;
    assign rx_err_o  = rx_err_q;
    assign rx_len_o  = rx_len_q;

    // =======================================================================
    // Sync-arrival timeout
    // =======================================================================
    logic             armed_q, armed_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             rx_to_q, rx_to_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            armed_q <= 1'b0;
            tmr_q   <= '0;
            rx_to_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
            tmr_q   <= tmr_d;
            rx_to_q <= rx_to_d;
        end
    end

    // Priority: sync detect (disarm) over a new arm over expiry. A re-arm on
    // the expiry cycle therefore restarts the window instead of timing out.
    always_comb begin
        armed_d = armed_q;
        tmr_d   = tmr_q;
        rx_to_d = 1'b0;
        if (sync_det) begin
            armed_d = 1'b0;
            tmr_d   = '0;
        end else if (TIMEOUT_EN && rx_arm_i) begin
            armed_d = 1'b1;
            tmr_d   = '0;
        end else if (armed_q) begin
            if (tmr_q == TMR_LAST) begin
                armed_d = 1'b0;
                tmr_d   = '0;
                rx_to_d = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_ONE;
            end
        end
    end

    assign rx_timeout_o = rx_to_q;

endmodule

// File: tb/tb_usb_line_xcvr.sv
// Testbench for usb_line_xcvr: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-schedule reference model.
module tb_usb_line_xcvr;
    localparam int SYNC_BITS  = 8;
    localparam int EOP_CYCLES = 2;
    localparam int MAX_BITS   = 127;
    localparam int RX_TIMEOUT = 255;
    // One bit wider than the minimum so an over-long tx_len can be presented.
    localparam int LEN_W      = 8;

    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic tx_start = 1'b0, tx_bit = 1'b0;
    logic [LEN_W-1:0] tx_len = '0;
    logic tx_bit_req, tx_busy, tx_done, oe, dp_w, dm_w;
    logic dp_r = 1'b1, dm_r = 1'b0, rx_en = 1'b0, rx_arm = 1'b0;
    logic rx_valid, rx_bit, rx_done, rx_err, rx_timeout;
    logic [LEN_W-1:0] rx_len;

    usb_line_xcvr #(
        .SYNC_BITS(SYNC_BITS), .EOP_CYCLES(EOP_CYCLES), .MAX_BITS(MAX_BITS),
        .RX_TIMEOUT(RX_TIMEOUT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .tx_start_i(tx_start), .tx_len_i(tx_len), .tx_bit_i(tx_bit),
        .tx_bit_req_o(tx_bit_req), .tx_busy_o(tx_busy), .tx_done_o(tx_done),
        .oe_o(oe), .dp_w_o(dp_w), .dm_w_o(dm_w),
        .dp_r_i(dp_r), .dm_r_i(dm_r), .rx_en_i(rx_en), .rx_arm_i(rx_arm),
        .rx_valid_o(rx_valid), .rx_bit_o(rx_bit), .rx_done_o(rx_done),
        .rx_len_o(rx_len), .rx_err_o(rx_err), .rx_timeout_o(rx_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // TX as a schedule: cycle k of a busy period is data (k<n), SE0
    // (k<n+EOP) or the closing J. RX as sync progress / bit count / SE0 run.
    bit     m_tx_act;
    int     m_tx_k, m_tx_n;
    bit     m_in_pkt;
    int     m_sync, m_nbits, m_se0, m_len;
    bit     m_done, m_err, m_to, m_armed;
    longint m_cyc, m_due;

    function automatic bit want_k(input int i);
        return (i == SYNC_BITS - 1) || (i % 2 == 0);
    endfunction

    task automatic model_reset();
        m_tx_act = 0; m_tx_k = 0; m_tx_n = 0;
        m_in_pkt = 0; m_sync = 0; m_nbits = 0; m_se0 = 0; m_len = 0;
        m_done = 0; m_err = 0; m_to = 0; m_armed = 0; m_due = 0;
    endtask

    task automatic model_step();
        bit act, hit;
        logic [1:0] sym;
        m_cyc++;
        sym = {dp_r, dm_r};
        act = rx_en && !m_tx_act;
        hit = 0;
        m_done = 0; m_err = 0; m_to = 0;
        if (!act) begin
            m_in_pkt = 0; m_sync = 0; m_nbits = 0; m_se0 = 0;
        end else if (!m_in_pkt) begin
            if (sym == (want_k(m_sync) ? K : J)) begin
                if (m_sync == SYNC_BITS - 1) begin
                    m_in_pkt = 1; m_nbits = 0; m_sync = 0; hit = 1;
                end else m_sync++;
            end else m_sync = (sym == K) ? 1 : 0;
        end else if (m_se0 == 0) begin
            if (sym == J || sym == K) begin
                if (m_nbits == MAX_BITS) begin m_err = 1; m_in_pkt = 0; end
                else m_nbits++;
            end else if (sym == SE0) m_se0 = 1;
            else begin m_err = 1; m_in_pkt = 0; end
        end else begin
            if (sym == SE0) m_se0++;
            else begin
                if (sym == J && m_se0 >= EOP_CYCLES) begin m_done = 1; m_len = m_nbits; end
                else m_err = 1;
                m_in_pkt = 0; m_se0 = 0;
            end
        end
        if (hit) m_armed = 0;
        else if (rx_arm && RX_TIMEOUT != 0) begin m_armed = 1; m_due = m_cyc + RX_TIMEOUT; end
        else if (m_armed && m_cyc == m_due) begin m_to = 1; m_armed = 0; end
        if (!m_tx_act) begin
            if (tx_start && tx_len != 0) begin
                m_tx_act = 1; m_tx_k = 0;
                m_tx_n = (int'(tx_len) > MAX_BITS) ? MAX_BITS : int'(tx_len);
            end
        end else if (m_tx_k == m_tx_n + EOP_CYCLES) m_tx_act = 0;
        else m_tx_k++;
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_b);
            if (!rst_b) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare + activity monitor ----------------
    int mon_oe, mon_req, mon_busy, mon_tdone, mon_tdone_at;
    int mon_valid, mon_rdone, mon_err, mon_to;

    task automatic clr_mon();
        mon_oe = 0; mon_req = 0; mon_busy = 0; mon_tdone = 0; mon_tdone_at = 0;
        mon_valid = 0; mon_rdone = 0; mon_err = 0; mon_to = 0;
    endtask

    initial begin
        bit e_req, e_oe, e_dp, e_dm, e_tdone, e_valid;
        logic [1:0] sym;
        clr_mon();
        forever begin
            @(negedge clk);
            e_req = 0; e_oe = 0; e_dp = 1; e_dm = 0; e_tdone = 0;
            if (m_tx_act) begin
                e_oe = 1;
                if (m_tx_k < m_tx_n) begin e_req = 1; e_dp = tx_bit; e_dm = ~tx_bit; end
                else if (m_tx_k < m_tx_n + EOP_CYCLES) begin e_dp = 0; e_dm = 0; end
                else e_tdone = 1;
            end
            sym = {dp_r, dm_r};
            e_valid = rx_en && !m_tx_act && m_in_pkt && m_se0 == 0 &&
                      (sym == J || sym == K) && m_nbits < MAX_BITS;
            chk("tx_busy", int'(tx_busy), int'(m_tx_act));
            chk("tx_bit_req", int'(tx_bit_req), int'(e_req));
            chk("oe", int'(oe), int'(e_oe));
            chk("dp_w", int'(dp_w), int'(e_dp));
            chk("dm_w", int'(dm_w), int'(e_dm));
            chk("tx_done", int'(tx_done), int'(e_tdone));
            chk("rx_valid", int'(rx_valid), int'(e_valid));
            chk("rx_bit", int'(rx_bit), int'(e_valid & dp_r));
            chk("rx_done", int'(rx_done), int'(m_done));
            chk("rx_err", int'(rx_err), int'(m_err));
            chk("rx_timeout", int'(rx_timeout), int'(m_to));
            chk("rx_len", int'(rx_len), m_len);
            mon_oe    += int'(oe);
            mon_req   += int'(tx_bit_req);
            mon_busy  += int'(tx_busy);
            mon_valid += int'(rx_valid);
            mon_rdone += int'(rx_done);
            mon_err   += int'(rx_err);
            mon_to    += int'(rx_timeout);
            if (tx_done) begin mon_tdone++; mon_tdone_at = mon_busy; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic line(input logic [1:0] s);
        {dp_r, dm_r} = s;
        step();
    endtask

    task automatic sync_seq();
        logic [1:0] seq [8];
        seq = '{K, J, K, J, K, J, K, K};
        for (int i = 0; i < 8; i++) line(seq[i]);
    endtask

    task automatic rx_pkt(input int nbits, input int se0n, input logic [1:0] endsym);
        sync_seq();
        for (int i = 0; i < nbits; i++) line($urandom_range(1) ? J : K);
        for (int i = 0; i < se0n; i++) line(SE0);
        line(endsym);
        line(J);
        line(J);
    endtask

    // Runs one TX packet; tx_start is re-pulsed at cycle 'glitch' (ignored).
    task automatic run_tx(input int len, input logic [31:0] pat, input bit use_pat,
                          input int glitch);
        int n;
        n = (len > MAX_BITS) ? MAX_BITS : len;
        tx_start = 1'b1;
        tx_len   = LEN_W'(len);
        step();
        tx_start = 1'b0;
        for (int i = 0; i < n + EOP_CYCLES + 3; i++) begin
            tx_bit   = use_pat ? ((i < 32) ? pat[31 - i] : 1'b0) : 1'($urandom_range(1));
            tx_start = (i == glitch) && (i < n);
            tx_len   = LEN_W'($urandom_range(1, 255));
            {dp_r, dm_r} = 2'($urandom_range(3));
            step();
        end
        tx_start = 1'b0;
        {dp_r, dm_r} = J;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        #1 rst_b = 1'b0;
        step(); step();
        chk("reset_dp_w", int'(dp_w), 1);
        chk("reset_dm_w", int'(dm_w), 0);
        chk("reset_oe", int'(oe), 0);
        chk("reset_rx_len", int'(rx_len), 0);
        chk("reset_busy", int'(tx_busy), 0);
        rst_b = 1'b1;
        step();

        // 1: 32-bit packet, start re-pulsed mid-packet
        clr_mon();
        run_tx(32, {8'h80, 24'hA5A5A5}, 1'b1, 10);
        chk("t1_req_cycles", mon_req, 32);
        chk("t1_oe_cycles", mon_oe, 35);
        chk("t1_done_count", mon_tdone, 1);
        chk("t1_done_at", mon_tdone_at, 35);

        // 2: clean 16-bit packet
        rx_en = 1'b1;
        step();
        clr_mon();
        rx_pkt(16, 2, J);
        chk("t2_valid", mon_valid, 16);
        chk("t2_done", mon_rdone, 1);
        chk("t2_rx_len", int'(rx_len), 16);
        chk("t2_model_len", m_len, 16);

        // 3: false start before the real sync
        clr_mon();
        line(K); line(J); line(K); line(K);
        rx_pkt(10, 2, J);
        chk("t3_done", mon_rdone, 1);
        chk("t3_rx_len", int'(rx_len), 10);

        // 4: short EOP, then SE1 inside data
        clr_mon();
        rx_pkt(12, 1, J);
        chk("t4_err", mon_err, 1);
        chk("t4_no_done", mon_rdone, 0);
        chk("t4_len_held", int'(rx_len), 10);
        clr_mon();
        sync_seq();
        for (int i = 0; i < 5; i++) line($urandom_range(1) ? J : K);
        line(SE1); line(J); line(J);
        chk("t4_se1_err", mon_err, 1);
        chk("t4_se1_valid", mon_valid, 5);
        rx_pkt(3, 2, J);
        chk("t4_recover_len", int'(rx_len), 3);

        // 5: timeout on an idle line, then sync arriving in time
        clr_mon();
        rx_arm = 1'b1;
        step();
        rx_arm = 1'b0;
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_timeout && lat < 0) lat = i;
            @(posedge clk);
            #1;
        end
        chk("t5_latency", lat, 255);
        chk("t5_to_count", mon_to, 1);
        clr_mon();
        rx_arm = 1'b1;
        step();
        rx_arm = 1'b0;
        for (int i = 0; i < 92; i++) line(J);
        rx_pkt(4, 2, J);
        for (int i = 0; i < 300; i++) line(J);
        chk("t5_no_timeout", mon_to, 0);
        chk("t5_done", mon_rdone, 1);

        // 6: overflow, exact maximum, clamped TX length, reset mid-TX
        clr_mon();
        rx_pkt(130, 2, J);
        chk("t6_ovf_valid", mon_valid, 127);
        chk("t6_ovf_err", mon_err, 1);
        chk("t6_ovf_no_done", mon_rdone, 0);
        rx_pkt(127, 2, J);
        chk("t6_max_len", int'(rx_len), 127);
        clr_mon();
        run_tx(200, 32'h0, 1'b0, -1);
        chk("t6_clamp_req", mon_req, 127);
        chk("t6_clamp_oe", mon_oe, 130);
        tx_start = 1'b1;
        tx_len   = LEN_W'(50);
        step();
        tx_start = 1'b0;
        repeat (10) step();
        #2 rst_b = 1'b0;
        #1;
        chk("t6_rst_dp_w", int'(dp_w), 1);
        chk("t6_rst_dm_w", int'(dm_w), 0);
        chk("t6_rst_oe", int'(oe), 0);
        chk("t6_rst_busy", int'(tx_busy), 0);
        chk("t6_rst_rx_len", int'(rx_len), 0);
        step(); step();
        rst_b = 1'b1;
        step();

        // randomized mix, checked by the per-cycle compare
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(3))
                0: begin
                    rx_en = 1'($urandom_range(1));
                    run_tx(($urandom_range(9) == 0) ? 0 : $urandom_range(1, 255),
                           32'h0, 1'b0, $urandom_range(0, 20));
                end
                1: begin
                    rx_en  = 1'b1;
                    rx_arm = 1'($urandom_range(3) == 0);
                    step();
                    rx_arm = 1'b0;
                    rx_pkt($urandom_range(0, 130), $urandom_range(0, 3),
                           2'($urandom_range(3)));
                end
                2: begin
                    for (int i = 0; i < 20; i++) begin
                        rx_en  = 1'($urandom_range(7) != 0);
                        rx_arm = 1'($urandom_range(19) == 0);
                        line(2'($urandom_range(3)));
                    end
                    rx_arm = 1'b0;
                    rx_en  = 1'b1;
                end
                default: begin
                    rx_en = 1'b1;
                    sync_seq();
                    for (int i = 0; i < $urandom_range(1, 20); i++) line($urandom_range(1) ? J : K);
                    rx_en = 1'b0;
                    line(SE0);
                    rx_en = 1'b1;
                    line(SE0); line(SE0); line(J); line(J);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
